// File: rtl/riscv_mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Op codes follow the RV32M funct3 ordering, so bit 2 separates the
// divide group from the multiply group and bit 1 separates remainder
// from quotient inside the divide group.
`timescale 1ns/1ps
package riscv_mdu_seq_pkg;

    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    localparam int MDU_ITER_CNT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        ITER   = 2'd2,
        FINISH = 2'd3
    } mdu_state_t;

    function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/riscv_mdu_step.sv
// One combinational iteration of the MDU datapath.
//   acc_i     : {high word, low word} accumulator
//   operand_i : multiplicand (mul) or divisor (div)
//   is_div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_o     : next accumulator (for divide, bit 0 is left 0)
//   q_bit_o   : quotient bit produced by a divide step (0 for multiply)
// Multiply: low word holds the remaining multiplier bits; the partial
// product grows into the high word while everything shifts right.
// Divide: high word is the partial remainder, low word shifts the
// dividend out on the left and the quotient in on the right.
`timescale 1ns/1ps
module riscv_mdu_step #(
    parameter int WORD_WIDTH = 32
) (
    input  logic [2*WORD_WIDTH-1:0] acc_i,
    input  logic [WORD_WIDTH-1:0]   operand_i,
    input  logic                    is_div_i,
    output logic [2*WORD_WIDTH-1:0] acc_o,
    output logic                    q_bit_o
);

    logic [WORD_WIDTH:0] w_sum;
    logic [WORD_WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, acc_i[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, operand_i};
        // Remainder stays below the divisor, so the shifted value fits in
        // WORD_WIDTH+1 bits and the top bit of the difference is the borrow.
        w_trial = acc_i[2*WORD_WIDTH-1:WORD_WIDTH-1] - {1'b0, operand_i};
        q_bit_o = 1'b0;
        acc_o   = acc_i;
        if (is_div_i) begin
            q_bit_o = ~w_trial[WORD_WIDTH];
            if (!w_trial[WORD_WIDTH]) begin
                acc_o = {w_trial[WORD_WIDTH-1:0], acc_i[WORD_WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {acc_i[2*WORD_WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {w_sum, acc_i[WORD_WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WORD_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/riscv_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Handshake: a request is taken on a rising edge where mdu_valid_i,
// mdu_ready_o are high and kill_i is low; operands are captured only
// then. The result appears on result_o with a one-cycle result_valid_o
// pulse, during which the sequencer is already IDLE and ready.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   mdu_valid_i      : request valid
//   mdu_op_i         : MDU op code
//   operand_a_i/b_i  : rs1 / rs2 values
//   kill_i           : abort the in-flight operation (no pulse)
//   mdu_ready_o      : request can be accepted
//   busy_o           : operation in flight
//   result_o         : registered result, held until next completion
//   result_valid_o   : one-cycle completion pulse
`timescale 1ns/1ps
module riscv_mdu_seq
    import riscv_mdu_seq_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ITER_CNT   = WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mdu_valid_i,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic [WORD_WIDTH-1:0]   operand_a_i,
    input  logic [WORD_WIDTH-1:0]   operand_b_i,
    input  logic                    kill_i,
    output logic                    mdu_ready_o,
    output logic                    busy_o,
    output logic [WORD_WIDTH-1:0]   result_o,
    output logic                    result_valid_o
);

    localparam int CNT_W = $clog2(ITER_CNT);
    localparam int W     = WORD_WIDTH;

    mdu_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [MDU_OP_WIDTH-1:0] r_op;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [2*W-1:0]        r_acc;
    logic [W-1:0]          r_opnd;
    logic                  r_neg;
    logic                  r_special;
    logic [W-1:0]          r_result;
    logic                  r_result_valid;

    logic                  w_is_div;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [W-1:0]          w_mag_a;
    logic [W-1:0]          w_mag_b;
    logic                  w_neg;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic [W-1:0]          w_special_res;
    logic [2*W-1:0]        w_acc_next;
    logic                  w_q_bit;
    logic [2*W-1:0]        w_prod;
    logic [W-1:0]          w_quo;
    logic [W-1:0]          w_rem;
    logic [W-1:0]          w_final;

    assign mdu_ready_o    = (r_state == IDLE) & rst_n;
    assign busy_o         = (r_state != IDLE);
    assign result_o       = r_result;
    assign result_valid_o = r_result_valid;

    // Operand preparation: magnitudes, result sign and special cases.
    always_comb begin
        w_is_div   = mdu_is_div(r_op);
        w_a_neg    = r_a[W-1] & ((r_op == MDU_MULH) | (r_op == MDU_MULHSU) |
                                 (r_op == MDU_DIV)  | (r_op == MDU_REM));
        w_b_neg    = r_b[W-1] & ((r_op == MDU_MULH) | (r_op == MDU_DIV) |
                                 (r_op == MDU_REM));
        w_mag_a    = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_mag_b    = w_b_neg ? (~r_b + 1'b1) : r_b;
        // Remainder takes the dividend's sign; everything else the xor.
        w_neg      = (w_is_div & r_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = w_is_div & (r_b == '0);
        w_ovf      = ((r_op == MDU_DIV) | (r_op == MDU_REM)) &
                     (r_a == {1'b1, {(W-1){1'b0}}}) & (r_b == '1);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = r_op[1] ? r_a : '1;
        end else if (w_ovf) begin
            w_special_res = r_op[1] ? '0 : r_a;
        end
    end

    riscv_mdu_step #(.WORD_WIDTH(W)) u_step (
        .acc_i     (r_acc),
        .operand_i (r_opnd),
        .is_div_i  (w_is_div),
        .acc_o     (w_acc_next),
        .q_bit_o   (w_q_bit)
    );

    // Sign correction and half selection. Multiply negates the full
    // 64-bit product before the high word is picked.
    always_comb begin
        w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
        w_rem  = r_neg ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
        if (r_special) begin
            w_final = r_acc[W-1:0];
        end else if (w_is_div) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else if (r_op == MDU_MUL) begin
            w_final = w_prod[W-1:0];
        end else begin
            w_final = w_prod[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_opnd         <= '0;
            r_neg          <= 1'b0;
            r_special      <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (kill_i && (r_state != IDLE)) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (mdu_valid_i && !kill_i) begin
                            r_op    <= mdu_op_i;
                            r_a     <= operand_a_i;
                            r_b     <= operand_b_i;
                            r_state <= PREP;
                        end
                    end
                    PREP: begin
                        r_cnt     <= '0;
                        r_special <= w_div_zero | w_ovf;
                        if (w_div_zero || w_ovf) begin
                            r_neg   <= 1'b0;
                            r_acc   <= {{W{1'b0}}, w_special_res};
                            r_state <= FINISH;
                        end else begin
                            r_neg   <= w_neg;
                            // Divide shifts the dividend; multiply shifts the multiplier.
                            r_acc   <= {{W{1'b0}}, w_is_div ? w_mag_a : w_mag_b};
                            r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                            r_state <= ITER;
                        end
                    end
                    ITER: begin
                        r_acc <= w_acc_next | {{(2*W-1){1'b0}}, w_q_bit};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(ITER_CNT-1)) begin
                            r_state <= FINISH;
                        end
                    end
                    FINISH: begin
                        r_result       <= w_final;
                        r_result_valid <= 1'b1;
                        r_state        <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_mdu_seq.sv
`timescale 1ns/1ps
module tb_riscv_mdu_seq;
    import riscv_mdu_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdu_valid_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        kill_i;
    logic        mdu_ready_o;
    logic        busy_o;
    logic [31:0] result_o;
    logic        result_valid_o;

    always #5 clk = ~clk;

    riscv_mdu_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mdu_valid_i    (mdu_valid_i),
        .mdu_op_i       (mdu_op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .kill_i         (kill_i),
        .mdu_ready_o    (mdu_ready_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after an edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        mdu_valid_i = 1'b1;
        mdu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        exp_q.push_back(exp);
        #1;
        check("ready_at_issue", {31'd0, mdu_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        mdu_valid_i = 1'b0;
        operand_a_i = 32'hDEAD_BEEF;
        operand_b_i = 32'h1234_5678;
    endtask

    // Counts edges after the accepting edge until the pulse (bounded).
    task automatic collect(input string tag, input int exp_lat);
        int   lat = 0;
        logic got = 1'b0;
        logic leak = 1'b0;
        logic [31:0] exp;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (result_valid_o) got = 1'b1;
            else if (mdu_ready_o) leak = 1'b1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_ready_low"}, {31'd0, leak}, 32'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check(tag, result_o, exp);
    endtask

    task automatic one(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(op, a, b, exp);
        collect(tag, lat);
        @(posedge clk);
        #1;
        check({tag, "_pulse_width"}, {31'd0, result_valid_o}, 32'd0);
    endtask

    // Watches for a stray completion pulse over a window.
    task automatic no_pulse(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (result_valid_o) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        mdu_valid_i = 1'b0;
        mdu_op_i    = MDU_MUL;
        operand_a_i = '0;
        operand_b_i = '0;
        kill_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_valid", {31'd0, result_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, mdu_ready_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, mdu_ready_o}, 32'd1);

        // kill in IDLE blocks acceptance
        mdu_valid_i = 1'b1;
        kill_i      = 1'b1;
        @(posedge clk);
        #1;
        check("kill_idle_busy", {31'd0, busy_o}, 32'd0);
        mdu_valid_i = 1'b0;
        kill_i      = 1'b0;

        one("mul_7x6",      MDU_MUL,    32'd7,          32'd6,          32'd42,         34);
        one("mul_m3x5",     MDU_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  34);
        one("mulh_min",     MDU_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34);
        one("mulhsu_ones",  MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34);
        one("mulhu_ones",   MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34);
        one("div_m7_2",     MDU_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        one("rem_m7_2",     MDU_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        one("div_7_m2",     MDU_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34);
        one("rem_7_m2",     MDU_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          34);
        one("divu_100_7",   MDU_DIVU,   32'd100,        32'd7,          32'd14,         34);
        one("remu_100_7",   MDU_REMU,   32'd100,        32'd7,          32'd2,          34);
        one("divu_5_0",     MDU_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  2);
        one("rem_5_0",      MDU_REM,    32'd5,          32'd0,          32'd5,          2);
        one("div_ovf",      MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);
        one("rem_ovf",      MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);
        one("divu_big",     MDU_DIVU,   32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  34);

        // kill at iteration 10; last result was 0x0FFFFFFF
        mdu_valid_i = 1'b1;
        mdu_op_i    = MDU_MUL;
        operand_a_i = 32'd9;
        operand_b_i = 32'd9;
        @(posedge clk);
        #1;
        mdu_valid_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        check("kill_ready", {31'd0, mdu_ready_o}, 32'd1);
        check("kill_busy", {31'd0, busy_o}, 32'd0);
        check("kill_valid", {31'd0, result_valid_o}, 32'd0);
        check("kill_result_held", result_o, 32'h0FFF_FFFF);
        no_pulse("kill_no_pulse", 40);

        // reset mid-ITER
        mdu_valid_i = 1'b1;
        mdu_op_i    = MDU_MULHU;
        operand_a_i = 32'd123;
        operand_b_i = 32'd456;
        @(posedge clk);
        #1;
        mdu_valid_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_result", result_o, 32'd0);
        check("midrst_valid", {31'd0, result_valid_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_ready_low", {31'd0, mdu_ready_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", {31'd0, mdu_ready_o}, 32'd1);
        no_pulse("midrst_no_pulse", 40);

        // back-to-back: second request issued in the first pulse cycle
        issue(MDU_MUL, 32'd12, 32'd11, 32'd132);
        collect("b2b_first", 34);
        issue(MDU_MUL, 32'd3, 32'd5, 32'd15);
        collect("b2b_second", 34);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
